temp_result_filter: RTL and testbench

//  Downstream stage of tempFsm in the LELO temperature path. Issues periodic start pulses, captures

---
 rtl/temp_result_filter.sv | 175 +++++++++++++++++
 tb/tb_temp_result_filter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_result_filter.sv
// temp_result_filter: issues periodic conversion starts to tempFsm, captures results,
// block-averages 2^AVG_LOG2 samples and drives a hysteretic over-threshold alarm.
// Optional macro LELO_TEMP_MINMAX_EN adds minCount/maxCount raw-sample extremes.
module temp_result_filter #(
  parameter int WIDTH    = 8,
  parameter int AVG_LOG2 = 2,
  parameter int INTERVAL = 16,
  parameter int TIMEOUT  = 64,
  parameter int HYST     = 4
) (
  input  logic             lfClk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] thrHi,
  input  logic [WIDTH-1:0] cycles,
  input  logic             done,
  output logic             start,
  output logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] avg,
  output logic             avgValid,
  output logic             alarmHi,
  output logic             timeoutErr
`ifdef LELO_TEMP_MINMAX_EN
  ,
  output logic [WIDTH-1:0] minCount,
  output logic [WIDTH-1:0] maxCount
`endif
);

  localparam int IW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int AW = WIDTH + AVG_LOG2;
  localparam int NW = AVG_LOG2 + 1;
  localparam logic [IW-1:0] INT_LAST = IW'(INTERVAL - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [NW-1:0] N_LAST   = NW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, ACC} state_t;

  state_t           state_q;
  logic [IW-1:0]    int_cnt_q;
  logic [TW-1:0]    wait_cnt_q;
  logic             done_q;
  logic [WIDTH-1:0] cap_q;
  logic [AW-1:0]    acc_q;
  logic [NW-1:0]    n_q;
  logic             start_q;
  logic [WIDTH-1:0] sample_q;
  logic [WIDTH-1:0] avg_q;
  logic             avg_valid_q;
  logic             alarm_q;
  logic             tmo_q;
`ifdef LELO_TEMP_MINMAX_EN
  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] max_q;
`endif

  // Running sum including the sample being accumulated, and the block average it would give.
  logic [AW-1:0]    acc_d;
  logic [WIDTH-1:0] avg_d;
  logic [WIDTH-1:0] thr_lo_d;
  logic             done_rise;

  assign acc_d     = acc_q + AW'(cap_q);
  assign avg_d     = WIDTH'(acc_d >> AVG_LOG2);
  // Release level saturates at zero so small thresholds never wrap around.
  assign thr_lo_d  = (thrHi >= WIDTH'(HYST)) ? (thrHi - WIDTH'(HYST)) : '0;
  assign done_rise = done & ~done_q;

  // Interval timer free-runs only while enabled; disabled means parked at zero.
  always_ff @(posedge lfClk or posedge reset) begin
    if (reset) begin
      int_cnt_q <= '0;
    end else if (!en) begin
      int_cnt_q <= '0;
    end else if (int_cnt_q == INT_LAST) begin
      int_cnt_q <= '0;
    end else begin
      int_cnt_q <= int_cnt_q + IW'(1);
    end
  end

  // Delayed copy of done for rising-edge detection.
  always_ff @(posedge lfClk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done;
    end
  end

  // Conversion sequencer with capture, block averaging, alarm and timeout flag.
  always_ff @(posedge lfClk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      cap_q       <= '0;
      acc_q       <= '0;
      n_q         <= '0;
      start_q     <= 1'b0;
      sample_q    <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      alarm_q     <= 1'b0;
      tmo_q       <= 1'b0;
`ifdef LELO_TEMP_MINMAX_EN
      min_q       <= '1;
      max_q       <= '0;
`endif
    end else begin
      start_q     <= 1'b0;
      avg_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // A wrap that lands while busy is simply lost; only IDLE can launch.
          if (en && (int_cnt_q == INT_LAST)) begin
            state_q <= START;
            start_q <= 1'b1;
          end
        end
        START: begin
          state_q    <= WAIT;
          wait_cnt_q <= '0;
        end
        WAIT: begin
          if (done_rise) begin
            state_q <= ACC;
            cap_q   <= cycles;
          end else if (wait_cnt_q == TMO_LAST) begin
            state_q <= IDLE;
            tmo_q   <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + TW'(1);
          end
        end
        ACC: begin
          state_q  <= IDLE;
          sample_q <= cap_q;
          tmo_q    <= 1'b0;
          if (n_q == N_LAST) begin
            acc_q       <= '0;
            n_q         <= '0;
            avg_q       <= avg_d;
            avg_valid_q <= 1'b1;
            if (avg_d > thrHi) begin
              alarm_q <= 1'b1;
            end else if (avg_d < thr_lo_d) begin
              alarm_q <= 1'b0;
            end
          end else begin
            acc_q <= acc_d;
            n_q   <= n_q + NW'(1);
          end
`ifdef LELO_TEMP_MINMAX_EN
          if (cap_q < min_q) min_q <= cap_q;
          if (cap_q > max_q) max_q <= cap_q;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start      = start_q;
  assign sample     = sample_q;
  assign avg        = avg_q;
  assign avgValid   = avg_valid_q;
  assign alarmHi    = alarm_q;
  assign timeoutErr = tmo_q;
`ifdef LELO_TEMP_MINMAX_EN
  assign minCount   = min_q;
  assign maxCount   = max_q;
`endif

endmodule

// File: tb/tb_temp_result_filter.sv
// Bench for temp_result_filter: a tempFsm stand-in answers each start 5 cycles later with
// queued (or random) results; expectations come from plain averaging and alarm rules.
`timescale 1ns/1ps
module tb_temp_result_filter;

  logic       lfClk = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] thrHi;
  logic [7:0] cycles;
  logic       done;
  logic       start;
  logic [7:0] sample;
  logic [7:0] avg;
  logic       avgValid;
  logic       alarmHi;
  logic       timeoutErr;
`ifdef LELO_TEMP_MINMAX_EN
  logic [7:0] minCount;
  logic [7:0] maxCount;
`endif

  // Responder (tempFsm stand-in) and spurious-done sources.
  logic       resp_done;
  logic [7:0] resp_cyc;
  logic [7:0] resp_v;
  logic       spur_done;
  logic [7:0] spur_cyc;
  bit         resp_en;
  logic [7:0] resp_vals [256];
  int         resp_wr = 0;
  int         resp_rd = 0;

  assign done   = resp_done | spur_done;
  assign cycles = spur_done ? spur_cyc : resp_cyc;

  // Monitor state.
  int   cyc = 0;
  int   start_cnt = 0;
  int   last_start_cyc = 0;
  int   long_start_cnt = 0;
  int   av_cnt = 0;
  logic [7:0] last_avg = 8'd0;
  bit   start_prev = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  temp_result_filter #(.WIDTH(8), .AVG_LOG2(2), .INTERVAL(16), .TIMEOUT(64), .HYST(4)) dut (
    .lfClk(lfClk), .reset(reset), .en(en), .thrHi(thrHi), .cycles(cycles), .done(done),
    .start(start), .sample(sample), .avg(avg), .avgValid(avgValid), .alarmHi(alarmHi),
    .timeoutErr(timeoutErr)
`ifdef LELO_TEMP_MINMAX_EN
    , .minCount(minCount), .maxCount(maxCount)
`endif
  );

  always #5 lfClk = ~lfClk;

  always @(posedge lfClk) begin
    cyc++;
    #1;
    if (start === 1'b1) begin
      start_cnt++;
      last_start_cyc = cyc;
      if (start_prev) long_start_cnt++;
    end
    start_prev = (start === 1'b1);
    if (avgValid === 1'b1) begin
      av_cnt++;
      last_avg = avg;
    end
  end

  initial begin
    resp_done = 1'b0;
    resp_cyc  = 8'd0;
    forever begin
      @(posedge lfClk);
      #3;
      if (start === 1'b1 && resp_en) begin
        if (resp_rd < resp_wr) begin
          resp_v = resp_vals[resp_rd % 256];
          resp_rd++;
        end else begin
          resp_v = 8'($urandom_range(0, 255));
        end
        repeat (5) @(posedge lfClk);
        #3;
        resp_cyc  = resp_v;
        resp_done = 1'b1;
        repeat (2) @(posedge lfClk);
        #3;
        resp_done = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge lfClk);
      #2;
    end
  endtask

  task automatic push(input int v);
    resp_vals[resp_wr % 256] = 8'(v);
    resp_wr++;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    en        = 1'b0;
    spur_done = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(10);
  endtask

  task automatic wait_start(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (start_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_av(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (av_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Reference alarm rule: set above threshold, release below threshold minus hysteresis.
  function automatic bit alarm_next(input bit cur, input int a, input int thr);
    int lo;
    lo = (thr - 4 < 0) ? 0 : thr - 4;
    if (a > thr) return 1'b1;
    if (a < lo) return 1'b0;
    return cur;
  endfunction

  task automatic run_block(input int v[4]);
    bit ok;
    int base;
    for (int i = 0; i < 4; i++) push(v[i]);
    base = av_cnt;
    en = 1'b1;
    wait_av(base + 1, 120, ok);
    en = 1'b0;
    total_cnt++;
    if (!ok) $display("FAIL block_avgvalid: got no avgValid within 120 cycles, required one");
    else pass_cnt++;
    tick(3);
  endtask

  task automatic test_reset();
    int s0;
    do_reset();
    total_cnt++; if (start !== 1'b0) $display("FAIL reset_start: got %b required 0", start); else pass_cnt++;
    total_cnt++; if (avg !== 8'd0) $display("FAIL reset_avg: got %0d required 0", avg); else pass_cnt++;
    total_cnt++; if (sample !== 8'd0) $display("FAIL reset_sample: got %0d required 0", sample); else pass_cnt++;
    total_cnt++; if (avgValid !== 1'b0) $display("FAIL reset_avgvalid: got %b required 0", avgValid); else pass_cnt++;
    total_cnt++; if (alarmHi !== 1'b0) $display("FAIL reset_alarm: got %b required 0", alarmHi); else pass_cnt++;
    total_cnt++; if (timeoutErr !== 1'b0) $display("FAIL reset_timeout: got %b required 0", timeoutErr); else pass_cnt++;
`ifdef LELO_TEMP_MINMAX_EN
    total_cnt++; if (minCount !== 8'hFF) $display("FAIL reset_min: got %0d required 255", minCount); else pass_cnt++;
    total_cnt++; if (maxCount !== 8'd0) $display("FAIL reset_max: got %0d required 0", maxCount); else pass_cnt++;
`endif
    s0 = start_cnt;
    tick(100);
    total_cnt++; if (start_cnt !== s0) $display("FAIL idle_no_start: got %0d starts required 0", start_cnt - s0); else pass_cnt++;
  endtask

  task automatic test_basic();
    int c0, s0, a0;
    bit ok;
    do_reset();
    thrHi = 8'd255;
    push(10); push(12); push(14); push(16);
    c0 = cyc; s0 = start_cnt; a0 = av_cnt;
    en = 1'b1;
    wait_start(s0 + 1, 30, ok);
    total_cnt++; if (!ok || last_start_cyc != c0 + 16) $display("FAIL first_start: got cycle %0d required %0d", last_start_cyc - c0, 16); else pass_cnt++;
    wait_start(s0 + 2, 30, ok);
    total_cnt++; if (!ok || last_start_cyc != c0 + 32) $display("FAIL second_start: got cycle %0d required %0d", last_start_cyc - c0, 32); else pass_cnt++;
    wait_av(a0 + 1, 80, ok);
    en = 1'b0;
    tick(20);
    total_cnt++; if (!ok || av_cnt != a0 + 1) $display("FAIL basic_avgvalid_count: got %0d required 1", av_cnt - a0); else pass_cnt++;
    total_cnt++; if (last_avg !== 8'((10 + 12 + 14 + 16) / 4)) $display("FAIL basic_avg: got %0d required 13", last_avg); else pass_cnt++;
    total_cnt++; if (sample !== 8'd16) $display("FAIL basic_sample: got %0d required 16", sample); else pass_cnt++;
    total_cnt++; if (alarmHi !== 1'b0) $display("FAIL basic_alarm: got %b required 0", alarmHi); else pass_cnt++;
  endtask

  task automatic test_alarm_hyst();
    int avgs[3];
    bit exp[3];
    int v[4];
    avgs = '{101, 97, 95};
    exp  = '{1'b1, 1'b1, 1'b0};
    do_reset();
    thrHi = 8'd100;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 4; i++) v[i] = avgs[b];
      run_block(v);
      total_cnt++; if (avg !== 8'(avgs[b])) $display("FAIL hyst_avg%0d: got %0d required %0d", b, avg, avgs[b]); else pass_cnt++;
      total_cnt++; if (alarmHi !== exp[b]) $display("FAIL hyst_alarm%0d: got %b required %b", b, alarmHi, exp[b]); else pass_cnt++;
    end
  endtask

  task automatic test_random_blocks();
    int v[4];
    int sum, a, thr;
    bit exp_alarm;
    do_reset();
    exp_alarm = 1'b0;
    for (int b = 0; b < 6; b++) begin
      sum = 0;
      for (int i = 0; i < 4; i++) begin
        v[i] = $urandom_range(0, 255);
        sum += v[i];
      end
      a = sum / 4;
      thr = a + $urandom_range(0, 10) - 5;
      if (thr < 0) thr = 0;
      if (thr > 255) thr = 255;
      thrHi = 8'(thr);
      run_block(v);
      exp_alarm = alarm_next(exp_alarm, a, thr);
      total_cnt++; if (avg !== 8'(a)) $display("FAIL rand_avg%0d: got %0d required %0d", b, avg, a); else pass_cnt++;
      total_cnt++; if (alarmHi !== exp_alarm) $display("FAIL rand_alarm%0d: got %b required %b (avg %0d thr %0d)", b, alarmHi, exp_alarm, a, thr); else pass_cnt++;
      total_cnt++; if (sample !== 8'(v[3])) $display("FAIL rand_sample%0d: got %0d required %0d", b, sample, v[3]); else pass_cnt++;
    end
  endtask

  task automatic test_timeout();
    int s0, s1, st;
    bit ok;
    do_reset();
    thrHi = 8'd255;
    resp_en = 1'b0;
    s0 = start_cnt;
    en = 1'b1;
    wait_start(s0 + 1, 30, ok);
    st = last_start_cyc;
    s1 = start_cnt;
    while (cyc < st + 60) tick(1);
    total_cnt++; if (timeoutErr !== 1'b0) $display("FAIL timeout_early: got %b required 0", timeoutErr); else pass_cnt++;
    push(77);
    while (cyc < st + 70) tick(1);
    total_cnt++; if (timeoutErr !== 1'b1) $display("FAIL timeout_set: got %b required 1", timeoutErr); else pass_cnt++;
    total_cnt++; if (start_cnt != s1) $display("FAIL timeout_skip_slot: got %0d starts required 0", start_cnt - s1); else pass_cnt++;
    resp_en = 1'b1;
    while (cyc < st + 90) tick(1);
    en = 1'b0;
    total_cnt++; if (start_cnt != s1 + 1 || last_start_cyc != st + 80) $display("FAIL timeout_next_start: got cycle %0d required %0d", last_start_cyc - st, 80); else pass_cnt++;
    total_cnt++; if (timeoutErr !== 1'b0) $display("FAIL timeout_clear: got %b required 0", timeoutErr); else pass_cnt++;
    total_cnt++; if (sample !== 8'd77) $display("FAIL timeout_sample: got %0d required 77", sample); else pass_cnt++;
  endtask

  task automatic test_en_drop();
    int s;
    bit seen;
    do_reset();
    push(123);
    en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick(1);
      if (start === 1'b1) seen = 1'b1;
    end
    en = 1'b0;
    tick(15);
    total_cnt++; if (!seen || sample !== 8'd123) $display("FAIL endrop_capture: got %0d required 123", sample); else pass_cnt++;
    s = start_cnt;
    tick(40);
    total_cnt++; if (start_cnt != s) $display("FAIL endrop_no_start: got %0d starts required 0", start_cnt - s); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int s0, a0;
    bit ok;
    bit seen;
    do_reset();
    thrHi = 8'd255;
    push(7); push(9); push(200);
    s0 = start_cnt;
    en = 1'b1;
    wait_start(s0 + 3, 80, ok);
    tick(2);
    reset = 1'b1;
    tick(1);
    total_cnt++; if (!ok || sample !== 8'd0) $display("FAIL midreset_sample: got %0d required 0", sample); else pass_cnt++;
    total_cnt++; if (start !== 1'b0 || avg !== 8'd0 || timeoutErr !== 1'b0) $display("FAIL midreset_outputs: got start %b avg %0d tmo %b required all 0", start, avg, timeoutErr); else pass_cnt++;
    tick(2);
    push(40); push(40); push(40); push(40);
    a0 = av_cnt;
    reset = 1'b0;
    wait_av(a0 + 1, 120, ok);
    total_cnt++; if (!ok || avg !== 8'd40) $display("FAIL midreset_fresh_avg: got %0d required 40", avg); else pass_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick(1);
      if (start === 1'b1) seen = 1'b1;
    end
    reset = 1'b1;
    #1;
    total_cnt++; if (!seen || start !== 1'b0) $display("FAIL async_start_drop: got %b required 0", start); else pass_cnt++;
    en = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(10);
  endtask

  task automatic test_spurious_idle();
    int a0;
    do_reset();
    a0 = av_cnt;
    spur_cyc  = 8'd99;
    spur_done = 1'b1;
    tick(2);
    spur_done = 1'b0;
    tick(5);
    total_cnt++; if (sample !== 8'd0) $display("FAIL spurious_sample: got %0d required 0", sample); else pass_cnt++;
    total_cnt++; if (av_cnt != a0) $display("FAIL spurious_avgvalid: got %0d pulses required 0", av_cnt - a0); else pass_cnt++;
  endtask

`ifdef LELO_TEMP_MINMAX_EN
  task automatic test_minmax();
    int v[4];
    v = '{50, 20, 80, 20};
    do_reset();
    thrHi = 8'd255;
    run_block(v);
    total_cnt++; if (minCount !== 8'd20) $display("FAIL minmax_min: got %0d required 20", minCount); else pass_cnt++;
    total_cnt++; if (maxCount !== 8'd80) $display("FAIL minmax_max: got %0d required 80", maxCount); else pass_cnt++;
    spur_cyc  = 8'd5;
    spur_done = 1'b1;
    tick(2);
    spur_done = 1'b0;
    tick(5);
    total_cnt++; if (minCount !== 8'd20 || maxCount !== 8'd80) $display("FAIL minmax_spurious: got %0d/%0d required 20/80", minCount, maxCount); else pass_cnt++;
  endtask
`endif

  task automatic test_start_width();
    total_cnt++; if (long_start_cnt != 0) $display("FAIL start_width: got %0d multi-cycle starts required 0", long_start_cnt); else pass_cnt++;
  endtask

  initial begin
    reset     = 1'b1;
    en        = 1'b0;
    thrHi     = 8'd255;
    spur_done = 1'b0;
    spur_cyc  = 8'd0;
    resp_en   = 1'b1;
    test_reset();
    test_basic();
    test_alarm_hyst();
    test_random_blocks();
    test_timeout();
    test_en_drop();
    test_reset_mid();
    test_spurious_idle();
`ifdef LELO_TEMP_MINMAX_EN
    test_minmax();
`endif
    test_start_width();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
